// File: rtl/updown_seq_ctrl_if.sv
// Control/status bundle for the up/down phase sequencer.
// The master side drives the start, enable and limit controls.
// The slave side is the sequencer, which returns counters and status.
interface updown_seq_ctrl_if #(
    parameter int W = 8
);
    logic         CE;
    logic         START;
    logic         STOP;
    logic         MODE;
    logic         USE_DEF;
    logic [W-1:0] UP_LIM;
    logic [W-1:0] DN_LOAD;
    logic [W-1:0] inc;
    logic [W-1:0] dec;
    logic [1:0]   phase;
    logic         busy;
    logic         done;
    logic [W-1:0] pass_cnt;

    modport master (
        output CE, START, STOP, MODE, USE_DEF, UP_LIM, DN_LOAD,
        input  inc, dec, phase, busy, done, pass_cnt
    );

    modport slave (
        input  CE, START, STOP, MODE, USE_DEF, UP_LIM, DN_LOAD,
        output inc, dec, phase, busy, done, pass_cnt
    );
endinterface

// File: rtl/updown_seq_ctrl.sv
// Up/down phase sequencer.
// UP phase: inc counts from 0 to the latched limit.
// DOWN phase: dec is loaded and counts to 0.
// At the end of each pass, done pulses and pass_cnt advances. The sequencer
// then stops (one-shot) or starts another pass (continuous).
// All counting advances only on CE cycles. Every output is a register.
module updown_seq_ctrl #(
    parameter int W      = 8,
    parameter int DEF_UP = 6,
    parameter int DEF_DN = 3
) (
    input  logic              CLK,
    input  logic              RST,
    updown_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } phase_t;

    phase_t       state;
    logic [W-1:0] inc_q;
    logic [W-1:0] dec_q;
    logic [W-1:0] pass_q;
    logic [W-1:0] lim;
    logic [W-1:0] ld;
    logic         mode_q;
    logic         busy_q;
    logic         done_q;

    // Sequencer FSM and counters: RST first, then STOP, then per-phase CE work.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: non-blocking assignments here. Every register then samples
            // the pre-edge values, so the ordering of these statements does not matter.
            state  <= IDLE;
            inc_q  <= '0;
            dec_q  <= '0;
            pass_q <= '0;
            lim    <= '0;
            ld     <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.STOP) begin
                // Abort leaves pass_cnt intact. It is cleared only by the next START.
                state  <= IDLE;
                inc_q  <= '0;
                dec_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        inc_q <= '0;
                        dec_q <= '0;
                        if (bus.START) begin
                            state  <= UP;
                            busy_q <= 1'b1;
                            mode_q <= bus.MODE;
                            lim    <= (bus.USE_DEF && bus.UP_LIM == '0)
                                      ? W'(DEF_UP) : bus.UP_LIM;
                            ld     <= (bus.USE_DEF && bus.DN_LOAD == '0)
                                      ? W'(DEF_DN) : bus.DN_LOAD;
                            pass_q <= '0;
                        end
                    end
                    UP: begin
                        if (bus.CE) begin
                            if (inc_q < lim) begin
                                inc_q <= inc_q + W'(1);
                            end else begin
                                state <= DOWN;
                                dec_q <= ld;
                            end
                        end
                    end
                    DOWN: begin
                        if (bus.CE) begin
                            if (dec_q != '0) begin
                                dec_q <= dec_q - W'(1);
                            end else begin
                                done_q <= 1'b1;
                                pass_q <= pass_q + W'(1);
                                inc_q  <= '0;
                                if (mode_q) begin
                                    state <= UP;
                                end else begin
                                    state  <= IDLE;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        inc_q  <= '0;
                        dec_q  <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.inc      = inc_q;
    assign bus.dec      = dec_q;
    assign bus.phase    = state;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl. Expected values are hand-derived per step.
module tb_updown_seq_ctrl;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;

    updown_seq_ctrl_if #(.W(W)) bus();

    updown_seq_ctrl #(.W(W), .DEF_UP(6), .DEF_DN(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Expected UP/DOWN pattern for a pass with lim=2, ld=1 (5 CEs), indexed by k%5.
    int e2_inc [5] = '{0, 1, 2, 2, 2};
    int e2_dec [5] = '{0, 0, 0, 1, 0};
    int e2_ph  [5] = '{1, 1, 1, 2, 2};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_inc, input int e_dec,
                             input int e_ph, input int e_busy, input int e_done,
                             input int e_pass);
        check({tag, ".inc"},      32'(bus.inc),      e_inc);
        check({tag, ".dec"},      32'(bus.dec),      e_dec);
        check({tag, ".phase"},    32'(bus.phase),    e_ph);
        check({tag, ".busy"},     32'(bus.busy),     e_busy);
        check({tag, ".done"},     32'(bus.done),     e_done);
        check({tag, ".pass_cnt"}, 32'(bus.pass_cnt), e_pass);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // CE every 4th clock: three idle clocks, then one CE clock.
    task automatic ce_pulse();
        bus.CE = 1'b0;
        repeat (3) tick();
        bus.CE = 1'b1;
        tick();
        bus.CE = 1'b0;
    endtask

    initial begin
        bus.CE      = 1'b0;
        bus.START   = 1'b0;
        bus.STOP    = 1'b0;
        bus.MODE    = 1'b0;
        bus.USE_DEF = 1'b0;
        bus.UP_LIM  = '0;
        bus.DN_LOAD = '0;
        RST         = 1'b1;
        repeat (20) tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;

        // One-shot with defaults (lim=6, ld=3); CE on the START edge must not count.
        bus.MODE    = 1'b0;
        bus.USE_DEF = 1'b1;
        bus.START   = 1'b1;
        bus.CE      = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.CE    = 1'b0;
        check_all("t1.start", 0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            ce_pulse();
            check_all("t1.up", i, 0, 1, 1, 0, 0);
        end
        ce_pulse();
        check_all("t1.turn", 6, 3, 2, 1, 0, 0);
        for (int i = 2; i >= 0; i--) begin
            ce_pulse();
            check_all("t1.dn", 6, i, 2, 1, 0, 0);
        end
        ce_pulse();
        check_all("t1.end", 0, 0, 0, 0, 1, 1);
        tick();
        check_all("t1.after", 0, 0, 0, 0, 0, 1);
        ce_pulse();
        check_all("t1.idle_ce", 0, 0, 0, 0, 0, 1);

        // Continuous, lim=2, ld=1, CE every clock: done every 5 clocks.
        bus.MODE    = 1'b1;
        bus.USE_DEF = 1'b0;
        bus.UP_LIM  = 8'd2;
        bus.DN_LOAD = 8'd1;
        bus.START   = 1'b1;
        tick();
        bus.START = 1'b0;
        check_all("t2.start", 0, 0, 1, 1, 0, 0);
        bus.CE = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_all("t2.run", e2_inc[k % 5], e2_dec[k % 5], e2_ph[k % 5], 1,
                      (k % 5 == 0) ? 1 : 0, k / 5);
        end
        bus.STOP = 1'b1;
        tick();
        bus.STOP = 1'b0;
        bus.CE   = 1'b0;
        check_all("t2.stop", 0, 0, 0, 0, 0, 6);

        // STOP in DOWN with dec=2, together with CE and START.
        bus.MODE    = 1'b1;
        bus.UP_LIM  = 8'd1;
        bus.DN_LOAD = 8'd2;
        bus.START   = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.CE    = 1'b1;
        repeat (7) tick();
        check_all("t4.pre", 1, 2, 2, 1, 0, 1);
        bus.STOP  = 1'b1;
        bus.START = 1'b1;
        tick();
        check_all("t4.stop", 0, 0, 0, 0, 0, 1);
        bus.STOP  = 1'b0;
        bus.START = 1'b0;
        bus.CE    = 1'b0;
        tick();
        check_all("t4.hold", 0, 0, 0, 0, 0, 1);

        // START mid-UP with a new limit and mode is ignored.
        bus.MODE    = 1'b0;
        bus.UP_LIM  = 8'd3;
        bus.DN_LOAD = 8'd0;
        bus.START   = 1'b1;
        tick();
        bus.START = 1'b0;
        check_all("t5.start", 0, 0, 1, 1, 0, 0);
        bus.CE = 1'b1;
        tick();
        check_all("t5.c1", 1, 0, 1, 1, 0, 0);
        bus.START  = 1'b1;
        bus.UP_LIM = 8'd9;
        bus.MODE   = 1'b1;
        tick();
        bus.START = 1'b0;
        check_all("t5.c2", 2, 0, 1, 1, 0, 0);
        tick();
        check_all("t5.c3", 3, 0, 1, 1, 0, 0);
        tick();
        check_all("t5.turn", 3, 0, 2, 1, 0, 0);
        tick();
        check_all("t5.end", 0, 0, 0, 0, 1, 1);
        bus.CE = 1'b0;

        // lim=0, ld=0, no defaults, continuous: 1-cycle phases, wrap after 256 passes.
        bus.MODE    = 1'b1;
        bus.USE_DEF = 1'b0;
        bus.UP_LIM  = 8'd0;
        bus.DN_LOAD = 8'd0;
        bus.START   = 1'b1;
        tick();
        bus.START = 1'b0;
        check_all("t3.start", 0, 0, 1, 1, 0, 0);
        bus.CE = 1'b1;
        for (int k = 1; k <= 514; k++) begin
            tick();
            check_all("t3.run", 0, 0, (k % 2 == 1) ? 2 : 1, 1,
                      (k % 2 == 0) ? 1 : 0, (k / 2) % 256);
        end
        // Now in UP with pass_cnt=1; synchronous reset mid-UP.
        RST = 1'b1;
        tick();
        check_all("rst_mid", 0, 0, 0, 0, 0, 0);
        RST    = 1'b0;
        bus.CE = 1'b0;
        tick();
        check_all("rst_after", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
- Parametrised up/down phase sequencer for the counter subsystem.
- In the UP phase, an incrementing counter runs from 0 to a runtime limit. In the DOWN phase, a decrementing counter is loaded and runs to 0. It then either stops (one-shot) or repeats (continuous).
- All counting advances only on CE clock-enable cycles. Outputs feed status and display logic; a per-pass DONE pulse and a pass counter are provided.

Parameters:
W, 8, width of inc, dec, limit inputs and pass counter
DEF_UP, 6, up limit used when UP_LIM input is 0 and USE_DEF is 1
DEF_DN, 3, down load used when DN_LOAD input is 0 and USE_DEF is 1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
CE  input  1  count enable; one-cycle strobe, may be high on consecutive cycles
START  input  1  begin sequencing; sampled in IDLE only
STOP  input  1  synchronous abort to IDLE
MODE  input  1  0 = one-shot, 1 = continuous; latched at START
USE_DEF  input  1  1 = a zero UP_LIM/DN_LOAD is replaced by DEF_UP/DEF_DN; latched at START
UP_LIM  input  W  up-phase terminal value; latched at START
DN_LOAD  input  W  down-phase load value; latched at START
inc  output  W  up counter
dec  output  W  down counter
phase  output  2  0 = IDLE, 1 = UP, 2 = DOWN
busy  output  1  high when phase != IDLE
done  output  1  one-cycle pulse at end of each DOWN phase
pass_cnt  output  W  completed passes since START; wraps modulo 2^W

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high.
- Reset values: inc=0, dec=0, phase=IDLE, busy=0, done=0, pass_cnt=0. Latched MODE, limit and load registers are also cleared to 0.
- RST overrides every other input. STOP overrides START and CE. All outputs are registered.
- done defaults to 0 every cycle unless set as described below.

IDLE:
- inc and dec hold 0.
- START=1 and STOP=0 causes the following on the next edge:
  - phase becomes UP.
  - MODE is latched.
  - lim = (USE_DEF && UP_LIM==0) ? DEF_UP : UP_LIM
  - ld = (USE_DEF && DN_LOAD==0) ? DEF_DN : DN_LOAD
  - pass_cnt is cleared.
- CE is ignored in IDLE. The START edge itself never counts, even if CE=1 on that cycle.

UP:
- On a CE cycle with inc < lim: inc <= inc+1.
- On a CE cycle with inc == lim: phase <= DOWN, dec <= ld. inc holds at lim.
- If lim == 0, the first CE moves to DOWN.
- Non-CE cycles hold all state.

DOWN:
- On a CE cycle with dec > 0: dec <= dec-1. inc holds at lim.
- On a CE cycle with dec == 0 (end of pass), all of the following happen on the same edge:
  - done <= 1 for one cycle.
  - pass_cnt <= pass_cnt+1, wrapping 2^W-1 to 0.
  - inc <= 0.
  - phase <= UP if the latched MODE is 1, otherwise IDLE.
- If ld == 0, the first CE in DOWN ends the pass.

Timing consequences:
- One pass takes exactly lim+1 CE cycles in UP plus ld+1 CE cycles in DOWN.
- In one-shot mode, busy falls on the same edge that done rises.

Other rules:
- STOP in any state: next edge gives phase=IDLE, inc=0, dec=0, no done pulse. pass_cnt holds its value until the next START.
- START while UP or DOWN is ignored, including changes to UP_LIM, DN_LOAD and MODE.
- Limit range: values up to 2^W-1 are legal. inc never exceeds lim, and no arithmetic overflows except the pass_cnt wrap.
- Continuous mode runs until STOP or RST.

Test Plan:
- RST held for 20 cycles, then CE every 4th clock, START=1 for one cycle with MODE=0, USE_DEF=1, UP_LIM=0, DN_LOAD=0 -> the following sequence, with each step on successive CE cycles:
  - inc goes 1,2,3,4,5,6 (6 CEs).
  - 7th CE: phase=DOWN, dec=3.
  - dec goes 2,1,0 over 3 CEs.
  - Next CE: done=1 for one clock, pass_cnt=1, inc=0, phase=IDLE, busy=0.
- MODE=1, UP_LIM=2, DN_LOAD=1, CE=1 continuously for 30 clocks -> inc cycles 0,1,2, then dec cycles 1,0. done pulses every 5 clocks, giving pass_cnt=6 at clock 30.
- UP_LIM=0, DN_LOAD=0, USE_DEF=0, MODE=1, CE=1 continuously -> UP and DOWN each last 1 cycle. done pulses every 2 clocks; inc and dec stay 0.
- STOP asserted during DOWN with dec=2, simultaneously with CE and START -> next edge phase=IDLE, inc=0, dec=0, done=0, and pass_cnt unchanged.
- START pulsed mid-UP with a new UP_LIM=9 -> ignored; inc still terminates at the original lim.
- Continuous run with UP_LIM=0, DN_LOAD=0 for 2^W passes -> pass_cnt wraps 255 to 0 with W=8. Then RST mid-UP -> all outputs return to their reset values on the next edge.
